// File: rtl/l1d_plru_pkg.sv
// Shared types and helpers for the tree-PLRU replacement controller.
package l1d_plru_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } fsm_state_e;

  typedef enum logic [1:0] {
    UPD_NONE  = 2'd0,
    UPD_TOUCH = 2'd1,
    UPD_VICT  = 2'd2,
    UPD_BOTH  = 2'd3
  } upd_mode_e;

  // Index (1-based) of the tree node visited at level lvl on the path to way.
  function automatic int unsigned node_idx(input int unsigned way,
                                           input int unsigned lvl,
                                           input int unsigned way_w);
    return (32'd1 << lvl) | (way >> (way_w - lvl));
  endfunction

endpackage

// File: rtl/lru_tree_update.sv
// Combinational tree-PLRU update: victim walk with path flip, then touch rule.
module lru_tree_update
  import l1d_plru_pkg::*;
#(
  parameter  int NWAY   = 8,
  localparam int WAY_W  = $clog2(NWAY),
  localparam int LRU_W  = NWAY - 1,
  localparam int NODE_W = WAY_W + 1
) (
  input  logic [LRU_W-1:0] vec_i,
  input  logic [WAY_W-1:0] touch_way_i,
  input  upd_mode_e        mode_i,
  output logic [LRU_W-1:0] vec_o,
  output logic [WAY_W-1:0] vict_way_o
);

  logic [NODE_W-1:0] node;
  logic              bit_v;
  logic              do_vict;
  logic              do_touch;

  assign do_vict  = (mode_i == UPD_VICT)  || (mode_i == UPD_BOTH);
  assign do_touch = (mode_i == UPD_TOUCH) || (mode_i == UPD_BOTH);

  always_comb begin
    vec_o      = vec_i;
    vict_way_o = '0;
    node       = NODE_W'(1);
    bit_v      = 1'b0;
    // Victim walk always reads the incoming vector so a touch never steers it.
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      bit_v                     = vec_i[node[WAY_W-1:0] - 1'b1];
      vict_way_o[WAY_W-1-lvl]   = bit_v;
      if (do_vict) begin
        vec_o[node[WAY_W-1:0] - 1'b1] = ~bit_v;
      end
      node = {node[WAY_W-1:0], bit_v};
    end
    if (do_touch) begin
      for (int lvl = 0; lvl < WAY_W; lvl++) begin
        node = NODE_W'(node_idx(32'(touch_way_i), 32'(lvl), 32'(WAY_W)));
        vec_o[node[WAY_W-1:0] - 1'b1] = ~touch_way_i[WAY_W-1-lvl];
      end
    end
  end

endmodule

// File: rtl/lru_repl_ctrl.sv
// Tree-PLRU replacement controller: per-set PLRU vectors, touch updates and a
// victim request/response FSM. Define LRU_REPL_PERF_CNT_EN to add perf counters.
module lru_repl_ctrl
  import l1d_plru_pkg::*;
#(
  parameter  int NSET  = 64,
  parameter  int NWAY  = 8,
  localparam int SET_W = $clog2(NSET),
  localparam int WAY_W = $clog2(NWAY),
  localparam int LRU_W = NWAY - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             touch_vld_i,
  input  logic [SET_W-1:0] touch_set_i,
  input  logic [WAY_W-1:0] touch_way_i,
  input  logic             vict_req_vld_i,
  output logic             vict_req_rdy_o,
  input  logic [SET_W-1:0] vict_req_set_i,
  output logic             vict_resp_vld_o,
  input  logic             vict_resp_rdy_i,
  output logic [SET_W-1:0] vict_resp_set_o,
  output logic [WAY_W-1:0] vict_resp_way_o
`ifdef LRU_REPL_PERF_CNT_EN
  ,
  output logic [31:0]      perf_touch_cnt_o,
  output logic [31:0]      perf_vict_cnt_o
`endif
);

  fsm_state_e       state_q, state_d;
  logic [SET_W-1:0] set_q, set_d;
  logic [WAY_W-1:0] way_q, way_d;
  logic [LRU_W-1:0] plru_q [NSET];
  logic [LRU_W-1:0] plru_d [NSET];

  logic             req_rdy;
  logic             resp_vld;
  logic             calc_hit;
  upd_mode_e        vict_mode;
  logic [LRU_W-1:0] calc_vec;
  logic [WAY_W-1:0] vict_way;
  logic [LRU_W-1:0] touch_vec;
  logic [WAY_W-1:0] unused_touch_way;

  assign calc_hit = (state_q == ST_CALC) && touch_vld_i && (touch_set_i == set_q);

  lru_tree_update #(.NWAY(NWAY)) u_calc (
    .vec_i       (plru_q[set_q]),
    .touch_way_i (touch_way_i),
    .mode_i      (vict_mode),
    .vec_o       (calc_vec),
    .vict_way_o  (vict_way)
  );

  lru_tree_update #(.NWAY(NWAY)) u_touch (
    .vec_i       (plru_q[touch_set_i]),
    .touch_way_i (touch_way_i),
    .mode_i      (touch_vld_i ? UPD_TOUCH : UPD_NONE),
    .vec_o       (touch_vec),
    .vict_way_o  (unused_touch_way)
  );

  always_comb begin
    state_d   = state_q;
    set_d     = set_q;
    way_d     = way_q;
    req_rdy   = 1'b0;
    resp_vld  = 1'b0;
    vict_mode = UPD_NONE;
    case (state_q)
      ST_IDLE: begin
        req_rdy = 1'b1;
        if (vict_req_vld_i) begin
          set_d   = vict_req_set_i;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        vict_mode = calc_hit ? UPD_BOTH : UPD_VICT;
        way_d     = vict_way;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        resp_vld = 1'b1;
        if (vict_resp_rdy_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A same-set touch in CALC is already folded into calc_vec.
  always_comb begin
    plru_d = plru_q;
    if (state_q == ST_CALC) begin
      plru_d[set_q] = calc_vec;
    end
    if (touch_vld_i && !calc_hit) begin
      plru_d[touch_set_i] = touch_vec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      set_q   <= '0;
      way_q   <= '0;
      plru_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      way_q   <= way_d;
      plru_q  <= plru_d;
    end
  end

  assign vict_req_rdy_o  = req_rdy & ~rst;
  assign vict_resp_vld_o = resp_vld & ~rst;
  assign vict_resp_set_o = rst ? '0 : set_q;
  assign vict_resp_way_o = rst ? '0 : way_q;

`ifdef LRU_REPL_PERF_CNT_EN
  logic [31:0] perf_touch_q, perf_touch_d;
  logic [31:0] perf_vict_q, perf_vict_d;

  always_comb begin
    perf_touch_d = perf_touch_q + (touch_vld_i ? 32'd1 : 32'd0);
    perf_vict_d  = perf_vict_q + ((resp_vld && vict_resp_rdy_i) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_touch_q <= '0;
      perf_vict_q  <= '0;
    end else begin
      perf_touch_q <= perf_touch_d;
      perf_vict_q  <= perf_vict_d;
    end
  end

  assign perf_touch_cnt_o = perf_touch_q;
  assign perf_vict_cnt_o  = perf_vict_q;
`endif

endmodule
